cache_wb_ctrl: RTL

Parametrised direct-mapped, write-back, write-allocate cache with an internal word-addressed backing RAM. It is the successor to the single-word write-through cache/RAM block: multi-word lines, dirty tracking, a configurable RAM access latency and a valid/ready request handshake. It sits between a core-side load/store port and the backing store, and accepts one outstanding request at a time.

---
 rtl/cache_wb_pkg.sv | 37 +++
 rtl/cache_wb_ram.sv | 49 ++++
 rtl/cache_wb_ctrl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/cache_wb_pkg.sv
// cache_wb_pkg: shared types and width helpers for the write-back cache.
//   state_t     - controller FSM states
//   line_meta_t - per-line valid/dirty/tag record. The tag field is stored at
//                 TAG_MAX_W bits so the struct is usable for any geometry;
//                 the controller zero-extends its real tag into it.
//   off_w/idx_w/tag_w - address field widths derived from the geometry.
package cache_wb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WB,
    FILL,
    RESP
  } state_t;

  localparam int TAG_MAX_W = 64;

  typedef struct packed {
    logic                 valid;
    logic                 dirty;
    logic [TAG_MAX_W-1:0] tag;
  } line_meta_t;

  function automatic int off_w(input int words_per_line);
    return $clog2(words_per_line);
  endfunction

  function automatic int idx_w(input int num_lines);
    return $clog2(num_lines);
  endfunction

  function automatic int tag_w(input int addr_w, input int num_lines, input int words_per_line);
    return addr_w - $clog2(num_lines) - $clog2(words_per_line);
  endfunction

endpackage

// File: rtl/cache_wb_ram.sv
// cache_wb_ram: word-addressed backing RAM with a RAM_LAT-cycle access.
//   clk, rst_n : clock, synchronous active-low reset (latency counter only)
//   start      : access request, held high for the whole access; holding it
//                high after done begins the next access immediately
//   we         : 1 = write wdata to addr when the access completes
//   addr       : word index (addr/we/wdata must stay stable until done)
//   wdata      : write data
//   rdata      : read data, valid in the cycle done is high
//   done       : high in the last cycle of each access (RAM_LAT cycles each)
// Contents are never cleared by reset.
module cache_wb_ram #(
  parameter int DATA_W    = 32,
  parameter int RAM_WORDS = 4096,
  parameter int RAM_LAT   = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         we,
  input  logic [$clog2(RAM_WORDS)-1:0] addr,
  input  logic [DATA_W-1:0]            wdata,
  output logic [DATA_W-1:0]            rdata,
  output logic                         done
);

  localparam int CNT_W = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;

  logic [DATA_W-1:0] mem [RAM_WORDS];
  logic [CNT_W-1:0]  cnt;

  assign done  = start && (cnt == CNT_W'(RAM_LAT - 1));
  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= done ? '0 : cnt + CNT_W'(1);
    end
  end

  // A write landing on a reset edge is dropped with the rest of the transfer.
  always_ff @(posedge clk) begin
    if (rst_n && done && we) begin
      mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/cache_wb_ctrl.sv
// cache_wb_ctrl: direct-mapped, write-back, write-allocate cache in front of
// an internal backing RAM (cache_wb_ram). One request outstanding at a time.
//   clk, rst_n          : clock, synchronous active-low reset
//   req_valid/req_ready : request handshake
//   req_we, req_addr, req_wdata : request fields (word address)
//   resp_valid          : one-cycle completion pulse
//   resp_rdata          : read data, or the written word for writes
//   resp_hit            : request hit in the cache
// Optional macro CACHE_WB_STATS_EN adds saturating 32-bit counters
// stat_hits, stat_misses, stat_writebacks.
//
// Handshake: a request transfers on the rising edge where req_valid &&
// req_ready. req_ready is high only in IDLE, so it drops the cycle after
// acceptance and rises again the cycle after the resp_valid pulse.
// The FSM state is visible on the internal signal 'state'.
module cache_wb_ctrl
  import cache_wb_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int NUM_LINES      = 64,
  parameter int WORDS_PER_LINE = 4,
  parameter int RAM_WORDS      = 4096,
  parameter int RAM_LAT        = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_hit
`ifdef CACHE_WB_STATS_EN
  ,
  output logic [31:0]       stat_hits,
  output logic [31:0]       stat_misses,
  output logic [31:0]       stat_writebacks
`endif
);

  localparam int OFF_W  = off_w(WORDS_PER_LINE);
  localparam int IDX_W  = idx_w(NUM_LINES);
  localparam int TAG_W  = tag_w(ADDR_W, NUM_LINES, WORDS_PER_LINE);
  localparam int RAM_AW = $clog2(RAM_WORDS);
  localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(WORDS_PER_LINE - 1);

  state_t             state;
  logic               we_q;
  logic [TAG_W-1:0]   tag_q;
  logic [IDX_W-1:0]   idx_q;
  logic [OFF_W-1:0]   off_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [OFF_W-1:0]   word_cnt;
  logic [OFF_W-1:0]   next_off;

  line_meta_t         meta [NUM_LINES];
  logic [DATA_W-1:0]  data_mem [NUM_LINES*WORDS_PER_LINE];
  line_meta_t         cur_meta;
  logic               hit;

  logic               ram_start;
  logic               ram_we;
  logic [RAM_AW-1:0]  ram_addr;
  logic [DATA_W-1:0]  ram_wdata;
  logic [DATA_W-1:0]  ram_rdata;
  logic               ram_done;

  assign cur_meta = meta[idx_q];
  assign hit      = cur_meta.valid && (cur_meta.tag == TAG_MAX_W'(tag_q));
  assign next_off = word_cnt + OFF_W'(1);

  cache_wb_ram #(
    .DATA_W    (DATA_W),
    .RAM_WORDS (RAM_WORDS),
    .RAM_LAT   (RAM_LAT)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .start (ram_start),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata),
    .done  (ram_done)
  );

  // ram_start stays high across consecutive word accesses (and across the
  // WB->FILL hand-over) so every word costs exactly RAM_LAT cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_hit   <= 1'b0;
      ram_start  <= 1'b0;
      ram_we     <= 1'b0;
      word_cnt   <= '0;
      for (int i = 0; i < NUM_LINES; i++) begin
        meta[i].valid <= 1'b0;
        meta[i].dirty <= 1'b0;
      end
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q                  <= req_we;
            {tag_q, idx_q, off_q} <= req_addr;
            wdata_q               <= req_wdata;
            req_ready             <= 1'b0;
            state                 <= LOOKUP;
          end
        end
        LOOKUP: begin
          word_cnt <= '0;
          if (hit) begin
            resp_hit <= 1'b1;
            if (we_q) begin
              data_mem[{idx_q, off_q}] <= wdata_q;
              meta[idx_q].dirty        <= 1'b1;
              resp_rdata               <= wdata_q;
            end else begin
              resp_rdata <= data_mem[{idx_q, off_q}];
            end
            resp_valid <= 1'b1;
            state      <= RESP;
          end else begin
            resp_hit  <= 1'b0;
            ram_start <= 1'b1;
            if (cur_meta.valid && cur_meta.dirty) begin
              ram_we    <= 1'b1;
              ram_addr  <= RAM_AW'({cur_meta.tag[TAG_W-1:0], idx_q, {OFF_W{1'b0}}});
              ram_wdata <= data_mem[{idx_q, {OFF_W{1'b0}}}];
              state     <= WB;
            end else begin
              ram_we   <= 1'b0;
              ram_addr <= RAM_AW'({tag_q, idx_q, {OFF_W{1'b0}}});
              state    <= FILL;
            end
          end
        end
        WB: begin
          if (ram_done) begin
            if (word_cnt == LAST_OFF) begin
              word_cnt <= '0;
              ram_we   <= 1'b0;
              ram_addr <= RAM_AW'({tag_q, idx_q, {OFF_W{1'b0}}});
              state    <= FILL;
            end else begin
              word_cnt  <= next_off;
              ram_addr  <= ram_addr + RAM_AW'(1);
              ram_wdata <= data_mem[{idx_q, next_off}];
            end
          end
        end
        FILL: begin
          if (ram_done) begin
            // The pending write is merged as its word arrives.
            data_mem[{idx_q, word_cnt}] <= (we_q && word_cnt == off_q) ? wdata_q : ram_rdata;
            if (word_cnt == off_q) begin
              resp_rdata <= we_q ? wdata_q : ram_rdata;
            end
            if (word_cnt == LAST_OFF) begin
              ram_start   <= 1'b0;
              meta[idx_q] <= '{valid: 1'b1, dirty: we_q, tag: TAG_MAX_W'(tag_q)};
              resp_valid  <= 1'b1;
              state       <= RESP;
            end else begin
              word_cnt <= next_off;
              ram_addr <= ram_addr + RAM_AW'(1);
            end
          end
        end
        RESP: begin
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          req_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

`ifdef CACHE_WB_STATS_EN
  // Hits/misses count at completion; write-backs when the last victim word lands.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_hits       <= '0;
      stat_misses     <= '0;
      stat_writebacks <= '0;
    end else begin
      if (state == RESP) begin
        if (resp_hit) begin
          if (stat_hits != '1) stat_hits <= stat_hits + 32'd1;
        end else begin
          if (stat_misses != '1) stat_misses <= stat_misses + 32'd1;
        end
      end
      if (state == WB && ram_done && word_cnt == LAST_OFF) begin
        if (stat_writebacks != '1) stat_writebacks <= stat_writebacks + 32'd1;
      end
    end
  end
`endif

endmodule
